dct_blk_arbiter: RTL

Block-level arbiter and sequencer sharing one forward DCT matrix core between two pixel-block requesters (e.g. luma and chroma paths). Grants whole 8x8 blocks (BEATS beats of two 8-bit pixels) round-robin and regenerates sob/eob framing toward the core. Records the source of each granted block in a tag FIFO so the DCT output stream can be attributed back to its requester.

---
 rtl/dct_blk_arbiter_if.sv | 33 +++
 rtl/dct_blk_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/dct_blk_arbiter_if.sv
// dct_blk_arbiter_if: requester, DCT-core and tag-return signals of the block arbiter
// slave  : arbiter side (drives req_ready, out_*, ret_src*, busy, err)
// master : environment side (drives en, req_*, ret_valid, ret_eob)
interface dct_blk_arbiter_if;
  logic            en;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req0_data;
  logic [1:0][7:0] req1_data;
  logic [1:0]      req_sob;
  logic [1:0]      req_eob;
  logic [1:0]      req_sof;
  logic [1:0]      req_ready;
  logic            out_valid;
  logic [1:0][7:0] out_data;
  logic            out_sob;
  logic            out_eob;
  logic            out_sof;
  logic            out_src;
  logic            ret_valid;
  logic            ret_eob;
  logic            ret_src;
  logic            ret_src_valid;
  logic            busy;
  logic            err;
  modport slave (
    input  en, req_valid, req0_data, req1_data, req_sob, req_eob, req_sof, ret_valid, ret_eob,
    output req_ready, out_valid, out_data, out_sob, out_eob, out_sof, out_src, ret_src, ret_src_valid, busy, err
  );
  modport master (
    output en, req_valid, req0_data, req1_data, req_sob, req_eob, req_sof, ret_valid, ret_eob,
    input  req_ready, out_valid, out_data, out_sob, out_eob, out_sof, out_src, ret_src, ret_src_valid, busy, err
  );
endinterface

// File: rtl/dct_blk_arbiter.sv
// dct_blk_arbiter: round-robin whole-block arbiter of two pixel requesters onto one DCT core
// clk, rst_n : clock, synchronous active-low reset
// bus        : dct_blk_arbiter_if.slave (requester beats in, framed beats to core, source tag return)
// DCT_ARB_CHK_EN : when defined, enables sticky protocol error detection on bus.err
module dct_blk_arbiter #(
  parameter int BEATS     = 32,
  parameter int TAG_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  dct_blk_arbiter_if.slave  bus
);
  localparam int CW = $clog2(BEATS);
  localparam int AW = $clog2(TAG_DEPTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state_q;
  logic            grant_q;
  logic            rr_last_q;
  logic [CW-1:0]   beat_cnt_q;
  logic [TAG_DEPTH-1:0] tag_q;
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [AW:0]     cnt_q;
  logic            out_valid_q;
  logic [1:0][7:0] out_data_q;
  logic            out_sob_q;
  logic            out_eob_q;
  logic            out_sof_q;
  logic            out_src_q;
  logic [1:0]      cand;
  logic            pick;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            first;
  logic            last;
  logic            accept;
  logic [1:0][7:0] data_sel;
  assign cand     = bus.req_valid & bus.req_sob;
  // on a tie the requester not served last wins
  assign pick     = (&cand) ? ~rr_last_q : cand[1];
  assign full     = cnt_q == (AW+1)'(TAG_DEPTH);
  assign empty    = cnt_q == '0;
  // full blocks the grant even if a pop frees a slot this same cycle
  assign push     = (state_q == IDLE) && bus.en && !full && |cand;
  assign pop      = bus.ret_valid && bus.ret_eob && !empty;
  assign first    = beat_cnt_q == '0;
  assign last     = beat_cnt_q == CW'(BEATS - 1);
  assign accept   = (state_q == BURST) && bus.req_valid[grant_q];
  assign data_sel = grant_q ? bus.req1_data : bus.req0_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      beat_cnt_q  <= '0;
      tag_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      if (push) begin
        state_q     <= BURST;
        grant_q     <= pick;
        rr_last_q   <= pick;
        beat_cnt_q  <= '0;
        tag_q[wr_q] <= pick;
        wr_q        <= wr_q + AW'(1);
      end
      if (accept) begin
        beat_cnt_q <= beat_cnt_q + CW'(1);
        out_data_q <= data_sel;
        out_src_q  <= grant_q;
        if (last) state_q <= IDLE;
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q       <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      // framing is regenerated from the beat counter, never copied from the requester
      out_valid_q <= accept;
      out_sob_q   <= accept && first;
      out_eob_q   <= accept && last;
      out_sof_q   <= accept && first && bus.req_sof[grant_q];
    end
  end
  assign bus.req_ready     = (state_q == BURST) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_sob       = out_sob_q;
  assign bus.out_eob       = out_eob_q;
  assign bus.out_sof       = out_sof_q;
  assign bus.out_src       = out_src_q;
  assign bus.ret_src       = !empty && tag_q[rd_q];
  assign bus.ret_src_valid = !empty;
  assign bus.busy          = state_q == BURST;
`ifdef DCT_ARB_CHK_EN
  logic err_q;
  logic err_now;
  // requester framing must agree with the beat counter; a return eob needs an outstanding tag
  assign err_now = (accept && bus.req_sob[grant_q] && !first)
                || (accept && (bus.req_eob[grant_q] != last))
                || (bus.ret_valid && bus.ret_eob && empty);
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else if (err_now) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  logic unused_eob;
  assign unused_eob = ^bus.req_eob;
  assign bus.err    = 1'b0;
`endif
endmodule
